// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO register with a one-cycle strobe.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        ON,
        END
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem;
    logic               q_neg;
    logic               r_neg;

    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               accept;
    logic               last;
    logic [WIDTH:0]     trial;
    logic [WIDTH+1:0]   diff;
    logic               step_neg;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   dvd_step;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               diff_unused;

    assign op1_neg = signed_div & opdata1[WIDTH-1];
    assign op2_neg = signed_div & opdata2[WIDTH-1];
    assign mag1    = op1_neg ? (-opdata1) : opdata1;
    assign mag2    = op2_neg ? (-opdata2) : opdata2;
    assign accept  = (state == IDLE) & start & ~annul;
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    // Shifted partial remainder is WIDTH+1 bits; the extra top bit
    // of the difference acts as the borrow of the trial subtract.
    assign trial       = {rem, dvd[WIDTH-1]};
    assign diff        = {1'b0, trial} - {2'b00, dsr};
    assign step_neg    = diff[WIDTH+1];
    assign diff_unused = diff[WIDTH];
    assign rem_step    = step_neg ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_step    = {dvd[WIDTH-2:0], ~step_neg};

    assign q_fix = q_neg ? (-dvd_step) : dvd_step;
    assign r_fix = r_neg ? (-rem_step) : rem_step;

    assign busy  = accept | (state == DIVZERO) | (state == ON);
    assign ready = (state == END);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !annul) begin
                    state_nxt = (opdata2 == '0) ? DIVZERO : ON;
                end
            end
            DIVZERO: state_nxt = annul ? IDLE : END;
            ON: begin
                if (annul) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = END;
                end
            end
            END: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && (opdata2 != '0)) begin
                        dvd   <= mag1;
                        dsr   <= mag2;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= op1_neg ^ op2_neg;
                        r_neg <= op1_neg;
                    end
                end
                DIVZERO: begin
                    if (!annul) begin
                        result <= '0;
                    end
                end
                ON: begin
                    if (!annul) begin
                        rem <= rem_step;
                        dvd <= dvd_step;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            result <= {r_fix, q_fix};
                        end
                    end
                end
                END: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a reference model fills a scoreboard
// queue at issue, and a monitor pops and compares on every ready strobe.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int          checks;
    int          failures;
    logic [63:0] exp_q[$];
    logic [63:0] last_want;
    logic [63:0] mon_want;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_div(signed_div),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .annul     (annul),
        .busy      (busy),
        .ready     (ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic sd,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'h0, 32'h8000_0000};
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    always @(negedge clk) begin
        if (resetn && ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready", 64'd1, 64'd0);
            end else begin
                mon_want = exp_q.pop_front();
                chk("result", result, mon_want);
            end
        end
    end

    task automatic issue(input logic sd, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1 chk("busy_accept", busy, 1);
        @(posedge clk);
        #1;
        start      = 1'b0;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
    endtask

    task automatic run_div(input logic sd, input logic [31:0] a,
                           input logic [31:0] b);
        int n;
        exp_q.push_back(model(sd, a, b));
        last_want = model(sd, a, b);
        issue(sd, a, b);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ready) break;
        end
        chk("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
        @(negedge clk);
        chk("idle_after", {62'd0, busy, ready}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        last_want  = '0;
        #3;
        chk("reset_ready", ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7);
        chk("u100_7", last_want, {32'h2, 32'hE});
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2);
        run_div(1'b0, 32'hFFFF_FFF9, 32'h2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h1);
        run_div(1'b0, 32'h1234_5678, 32'h0);
        run_div(1'b1, 32'h7, 32'hFFFF_FFFE);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_div(1'b0, 32'h5, 32'h9);
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_div(1'b0, 32'h1234_5678, 32'h8000_0000);
        run_div(1'b1, 32'h8000_0000, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            run_div(1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        run_div(1'b0, 32'd100, 32'd7);
        issue(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul_on_busy", busy, 0);
        chk("annul_on_result", result, last_want);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2);

        issue(1'b0, 32'd55, 32'd0);
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul_dz_busy", busy, 0);
        chk("annul_dz_result", result, last_want);

        @(posedge clk);
        #1;
        start   = 1'b1;
        annul   = 1'b1;
        opdata1 = 32'd9;
        opdata2 = 32'd4;
        #1 chk("start_annul_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        chk("start_annul_idle", busy, 0);
        repeat (40) @(negedge clk);

        issue(1'b0, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_ready", ready, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_result", result, 0);
        last_want = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        run_div(1'b1, 32'hFFFF_FF9C, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
